// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a data-processing instruction, evaluates its
// condition on forwarded N/Z/V flags and registers the ALU operands.
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rn_data,
    input  logic [DATA_WIDTH-1:0] rm_data,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic                  out_valid,
    output logic [3:0]            out_aluctrl,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [3:0]            out_rd,
    output logic                  out_wr_en,
    output logic                  out_set_flags,
    output logic                  illegal_instr,
    output logic [2:0]            flags_nzv
);

    logic [3:0] cond;
    logic [1:0] cls;
    logic       imm_sel;
    logic [3:0] op;
    logic       s_bit;
    logic [3:0] rd;

    assign cond    = instr[31:28];
    assign cls     = instr[27:26];
    assign imm_sel = instr[25];
    assign op      = instr[24:21];
    assign s_bit   = instr[20];
    assign rd      = instr[15:12];

    // Register specifiers arrive already resolved through rn_data/rm_data.
    logic unused_fields;
    assign unused_fields = ^instr[19:16];

    assign in_ready = !stall_in;

    logic [3:0] dec_ctrl;
    logic       dec_wr;
    logic       dec_force_sf;
    logic       dec_zero_a;
    logic       op_ok;

    always_comb begin
        dec_ctrl     = 4'b0000;
        dec_wr       = 1'b0;
        dec_force_sf = 1'b0;
        dec_zero_a   = 1'b0;
        op_ok        = 1'b1;
        unique case (op)
            4'b0000: begin dec_ctrl = 4'b0011; dec_wr = 1'b1; end
            4'b0001: begin dec_ctrl = 4'b0101; dec_wr = 1'b1; end
            4'b0010: begin dec_ctrl = 4'b0010; dec_wr = 1'b1; end
            4'b0011: begin dec_ctrl = 4'b1010; dec_wr = 1'b1; end
            4'b0100: begin dec_ctrl = 4'b0001; dec_wr = 1'b1; end
            4'b0101: begin dec_ctrl = 4'b1000; dec_wr = 1'b1; end
            4'b0110: begin dec_ctrl = 4'b1001; dec_wr = 1'b1; end
            4'b1000: begin dec_ctrl = 4'b0011; dec_force_sf = 1'b1; end
            4'b1010: begin dec_ctrl = 4'b0010; dec_force_sf = 1'b1; end
            4'b1100: begin dec_ctrl = 4'b0100; dec_wr = 1'b1; end
            4'b1101: begin
                dec_ctrl   = 4'b0100;
                dec_wr     = 1'b1;
                dec_zero_a = 1'b1;
            end
            default: op_ok = 1'b0;
        endcase
    end

    // Flags from the instruction in EX override the committed copy.
    logic ex_live;
    logic n_f;
    logic z_f;
    logic v_f;
    logic [2:0] ex_flags;

    assign ex_live  = out_valid && out_set_flags;
    assign ex_flags = {alu_result[DATA_WIDTH-1],
                       alu_result == '0,
                       alu_overflow};
    assign {n_f, z_f, v_f} = ex_live ? ex_flags : flags_nzv;

    logic cond_ok;
    logic cond_pass;

    always_comb begin
        cond_ok   = 1'b1;
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic legal;
    logic accept;
    logic issue;
    logic [DATA_WIDTH-1:0] opnd_a;
    logic [DATA_WIDTH-1:0] opnd_b;

    assign legal  = op_ok && cond_ok && (cls == 2'b00);
    assign accept = in_valid && !stall_in && !flush;
    assign issue  = in_valid && legal && cond_pass;
    assign opnd_a = dec_zero_a ? '0 : rn_data;
    assign opnd_b = imm_sel
                  ? {{(DATA_WIDTH-12){1'b0}}, instr[11:0]}
                  : rm_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_aluctrl   <= 4'b0000;
            out_a         <= '0;
            out_b         <= '0;
            out_rd        <= 4'h0;
            out_wr_en     <= 1'b0;
            out_set_flags <= 1'b0;
            illegal_instr <= 1'b0;
            flags_nzv     <= 3'b000;
        end else begin
            illegal_instr <= accept && !legal;
            if (!stall_in) begin
                if (ex_live)
                    flags_nzv <= ex_flags;
                if (!flush && issue) begin
                    out_valid     <= 1'b1;
                    out_aluctrl   <= dec_ctrl;
                    out_a         <= opnd_a;
                    out_b         <= opnd_b;
                    out_rd        <= rd;
                    out_wr_en     <= dec_wr;
                    out_set_flags <= s_bit || dec_force_sf;
                end else begin
                    out_valid     <= 1'b0;
                    out_aluctrl   <= 4'b0000;
                    out_a         <= '0;
                    out_b         <= '0;
                    out_rd        <= 4'h0;
                    out_wr_en     <= 1'b0;
                    out_set_flags <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table plus flag-forwarding,
// stall, flush and reset sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic        stall_in;
    logic        flush;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        out_valid;
    logic [3:0]  out_aluctrl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_rd;
    logic        out_wr_en;
    logic        out_set_flags;
    logic        illegal_instr;
    logic [2:0]  flags_nzv;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rn_data(rn_data), .rm_data(rm_data),
        .stall_in(stall_in), .flush(flush),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_aluctrl(out_aluctrl),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_set_flags(out_set_flags),
        .illegal_instr(illegal_instr), .flags_nzv(flags_nzv)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        e_valid;
        logic [3:0]  e_ctrl;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_rd;
        logic        e_wr;
        logic        e_sf;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input logic [3:0] c, input logic i,
                                       input logic [3:0] op, input logic s,
                                       input logic [3:0] rd,
                                       input logic [11:0] o2);
        return {c, 2'b00, i, op, s, 4'h1, rd, o2};
    endfunction

    task automatic add(input string nm, input logic iv, input logic [31:0] ins,
                       input logic [31:0] rn, input logic [31:0] rm,
                       input logic ev, input logic [3:0] ec,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] erd, input logic ew,
                       input logic esf, input logic eil);
        vec_t v;
        v.name = nm; v.iv = iv; v.ins = ins; v.rn = rn; v.rm = rm;
        v.e_valid = ev; v.e_ctrl = ec; v.e_a = ea; v.e_b = eb;
        v.e_rd = erd; v.e_wr = ew; v.e_sf = esf; v.e_ill = eil;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    localparam logic [3:0] AL = 4'b1110;

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = '0;
        rn_data = '0; rm_data = '0; stall_in = 1'b0; flush = 1'b0;
        alu_result = 32'h1; alu_overflow = 1'b0;

        // Neutral EX feedback: nonzero positive result keeps flags at 000.
        add("add_al", 1, 32'hE081_2003, 5, 7, 1, 4'b0001, 5, 7, 2, 1, 0, 0);
        add("mov_imm", 1, mk(AL,1,4'b1101,0,4,12'h0FF), 32'h1234, 9,
            1, 4'b0100, 0, 32'hFF, 4, 1, 0, 0);
        add("and_s", 1, mk(AL,0,4'b0000,1,3,12'h004), 11, 12,
            1, 4'b0011, 11, 12, 3, 1, 1, 0);
        add("xnr_imm", 1, mk(AL,1,4'b0001,0,5,12'hABC), 1, 2,
            1, 4'b0101, 1, 32'hABC, 5, 1, 0, 0);
        add("sub", 1, mk(AL,0,4'b0010,0,6,0), 20, 4, 1, 4'b0010, 20, 4, 6, 1, 0, 0);
        add("slt", 1, mk(AL,0,4'b0011,0,7,0), 3, 4, 1, 4'b1010, 3, 4, 7, 1, 0, 0);
        add("lsl", 1, mk(AL,0,4'b0101,0,8,0), 3, 2, 1, 4'b1000, 3, 2, 8, 1, 0, 0);
        add("lsr", 1, mk(AL,0,4'b0110,0,9,0), 3, 2, 1, 4'b1001, 3, 2, 9, 1, 0, 0);
        add("tst", 1, mk(AL,0,4'b1000,0,0,0), 6, 6, 1, 4'b0011, 6, 6, 0, 0, 1, 0);
        add("cmp", 1, mk(AL,1,4'b1010,0,0,12'h009), 9, 1,
            1, 4'b0010, 9, 9, 0, 0, 1, 0);
        add("orr", 1, mk(AL,0,4'b1100,0,10,0), 8, 1, 1, 4'b0100, 8, 1, 10, 1, 0, 0);
        add("ill_op", 1, mk(AL,0,4'b0111,0,1,0), 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("ill_op_f", 1, mk(AL,0,4'b1111,0,1,0), 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("ill_cls", 1, mk(AL,0,4'b0100,0,1,0) | 32'h0400_0000, 1, 1,
            0, 0, 0, 0, 0, 0, 0, 1);
        add("ill_cond", 1, mk(4'b1111,0,4'b0100,0,1,0), 1, 1,
            0, 0, 0, 0, 0, 0, 0, 1);
        add("no_valid", 0, mk(AL,0,4'b0111,0,1,0), 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("ne_pass", 1, mk(4'b0001,0,4'b0100,0,2,0), 1, 2, 1, 4'b0001, 1, 2, 2, 1, 0, 0);
        add("eq_fail", 1, mk(4'b0000,0,4'b0100,0,2,0), 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add("pl_pass", 1, mk(4'b0101,0,4'b0100,0,3,0), 1, 2, 1, 4'b0001, 1, 2, 3, 1, 0, 0);
        add("mi_fail", 1, mk(4'b0100,0,4'b0100,0,3,0), 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add("vs_fail", 1, mk(4'b0110,0,4'b0100,0,3,0), 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add("vc_pass", 1, mk(4'b0111,0,4'b0100,0,4,0), 1, 2, 1, 4'b0001, 1, 2, 4, 1, 0, 0);
        add("ge_pass", 1, mk(4'b1010,0,4'b0100,0,4,0), 1, 2, 1, 4'b0001, 1, 2, 4, 1, 0, 0);
        add("lt_fail", 1, mk(4'b1011,0,4'b0100,0,4,0), 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add("gt_pass", 1, mk(4'b1100,0,4'b0100,0,5,0), 1, 2, 1, 4'b0001, 1, 2, 5, 1, 0, 0);
        add("le_fail", 1, mk(4'b1101,0,4'b0100,0,5,0), 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_aluctrl, 0);
        chk("rst_a", out_a, 0);
        chk("rst_b", out_b, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_wr", out_wr_en, 0);
        chk("rst_sf", out_set_flags, 0);
        chk("rst_ill", illegal_instr, 0);
        chk("rst_flags", flags_nzv, 0);
        chk("rst_ready", in_ready, 1);

        foreach (vecs[k]) begin
            in_valid = vecs[k].iv;
            instr    = vecs[k].ins;
            rn_data  = vecs[k].rn;
            rm_data  = vecs[k].rm;
            tick();
            chk({vecs[k].name, "_valid"}, out_valid, vecs[k].e_valid);
            chk({vecs[k].name, "_ill"}, illegal_instr, vecs[k].e_ill);
            chk({vecs[k].name, "_flags"}, flags_nzv, 0);
            if (vecs[k].e_valid) begin
                chk({vecs[k].name, "_ctrl"}, out_aluctrl, vecs[k].e_ctrl);
                chk({vecs[k].name, "_a"}, out_a, vecs[k].e_a);
                chk({vecs[k].name, "_b"}, out_b, vecs[k].e_b);
                chk({vecs[k].name, "_rd"}, out_rd, vecs[k].e_rd);
                chk({vecs[k].name, "_wr"}, out_wr_en, vecs[k].e_wr);
                chk({vecs[k].name, "_sf"}, out_set_flags, vecs[k].e_sf);
            end
        end
        in_valid = 1'b0;
        do_reset();

        // CMP equal, then EQ-conditioned ADD issues via forwarded Z
        in_valid = 1'b1;
        instr = mk(AL,1,4'b1010,0,0,12'h009); rn_data = 9;
        tick();
        alu_result = 0; alu_overflow = 0;
        instr = 32'h0081_2003; rn_data = 5; rm_data = 7;
        tick();
        chk("fwd_eq_valid", out_valid, 1);
        chk("fwd_eq_ctrl", out_aluctrl, 4'b0001);
        chk("fwd_eq_a", out_a, 5);
        chk("fwd_eq_b", out_b, 7);
        chk("fwd_eq_rd", out_rd, 2);
        chk("fwd_eq_wr", out_wr_en, 1);
        chk("fwd_eq_sf", out_set_flags, 0);
        chk("fwd_eq_flags", flags_nzv, 3'b010);

        // CMP 8 vs 9 -> negative result, EQ ADD squashed
        instr = mk(AL,1,4'b1010,0,0,12'h009); rn_data = 8;
        tick();
        alu_result = 32'hFFFF_FFFF;
        instr = 32'h0081_2003; rn_data = 5; rm_data = 7;
        tick();
        chk("fwd_ne_valid", out_valid, 0);
        chk("fwd_ne_wr", out_wr_en, 0);
        chk("fwd_ne_flags", flags_nzv, 3'b100);

        // Illegal op: pulse, bubble, flags untouched
        instr = mk(AL,0,4'b0111,0,1,0);
        tick();
        chk("ill_pulse", illegal_instr, 1);
        chk("ill_valid", out_valid, 0);
        chk("ill_flags", flags_nzv, 3'b100);
        in_valid = 1'b0;
        tick();
        chk("ill_clear", illegal_instr, 0);

        // Stall with CMP in EX: hold and no commit
        in_valid = 1'b1;
        instr = mk(AL,1,4'b1010,0,0,12'h003); rn_data = 3;
        tick();
        alu_result = 0;
        instr = mk(AL,0,4'b0100,0,6,0); rn_data = 1; rm_data = 2;
        stall_in = 1'b1;
        #1;
        chk("stall_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_ctrl", out_aluctrl, 4'b0010);
            chk("stall_b", out_b, 3);
            chk("stall_flags", flags_nzv, 3'b100);
            chk("stall_ill", illegal_instr, 0);
        end
        stall_in = 1'b0;
        tick();
        chk("rel_ctrl", out_aluctrl, 4'b0001);
        chk("rel_a", out_a, 1);
        chk("rel_b", out_b, 2);
        chk("rel_rd", out_rd, 6);
        chk("rel_flags", flags_nzv, 3'b010);

        // Flush kills ID ADD while the CMP in EX still commits
        instr = mk(AL,1,4'b1010,0,0,12'h001); rn_data = 0;
        tick();
        alu_result = 32'hFFFF_FFFF; alu_overflow = 1'b1;
        instr = mk(AL,0,4'b0100,0,7,0);
        flush = 1'b1;
        #1;
        chk("flush_ready", in_ready, 1);
        tick();
        flush = 1'b0;
        alu_overflow = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_aluctrl, 0);
        chk("flush_flags", flags_nzv, 3'b101);
        chk("flush_ill", illegal_instr, 0);

        // Reset mid-stream
        tick();
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ctrl", out_aluctrl, 0);
        chk("mid_rst_a", out_a, 0);
        chk("mid_rst_rd", out_rd, 0);
        chk("mid_rst_wr", out_wr_en, 0);
        chk("mid_rst_flags", flags_nzv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
